sysmem_ctrl: RTL

Bus-side responder for the on-chip system memory: it accepts picorv32 native memory-interface transactions and drives four 1024x8 single-port byte-lane BRAMs (one per byte of a 32-bit word). It decodes its address window, sequences BRAM chip-enable and write-enable per byte strobe, returns registered read data, and generates the `mem_ready` handshake. It sits between the CPU's memory bus and the byte-lane `sysmem_*` RAM instances.

---
 rtl/sysmem_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/sysmem_ctrl.sv
// System memory responder: picorv32 native bus to four 1024x8 byte-lane BRAMs.
// Optional write protection of the low WP_WORDS words is enabled by defining SYSMEM_WP_EN.
module sysmem_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          WP_WORDS   = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_ce,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_di,
    input  logic [31:0]           ram_do,
    output logic                  err_wp
);

`ifdef SYSMEM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    state_t state, state_nxt;
    logic   hit, accept, is_wr, in_wp, wp_block;
    logic   unused_bits;

    assign unused_bits = ^mem_addr[1:0];
    assign hit      = mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
    assign accept   = (state == IDLE) && mem_valid && hit;
    assign is_wr    = |mem_wstrb;
    assign in_wp    = 32'(mem_addr[ADDR_WIDTH+1:2]) < 32'(WP_WORDS);
    // A blocked write is still acknowledged, it just never reaches the RAM.
    assign wp_block = WP_EN && is_wr && in_wp;

    assign ram_addr = mem_addr[ADDR_WIDTH+1:2];
    assign ram_di   = mem_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mem_rdata <= '0;
            err_wp    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RD)
                mem_rdata <= ram_do;
            if (accept && wp_block)
                err_wp <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_wr ? RESP : RD;
            RD:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_ce    = 4'h0;
        ram_we    = 4'h0;
        mem_ready = (state == RESP);
        if (accept) begin
            if (!is_wr) begin
                ram_ce = 4'hF;
            end else if (!wp_block) begin
                ram_ce = mem_wstrb;
                ram_we = mem_wstrb;
            end
        end
    end

endmodule
